// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: ID/EX hazard inputs plus PC/pipeline-register controls.
// The master modport drives the pipeline inputs. The slave modport is the controller side.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int NREG  = 4
);
  logic [REG_W-1:0] rs1_id;
  logic [REG_W-1:0] rs2_id;
  logic             rs1_used_id;
  logic             rs2_used_id;
  logic             ex_valid;
  logic             ex_mem_read;
  logic [REG_W-1:0] rd_ex;
  logic             mdu_start;
  logic             mdu_done;
  logic             imem_stall;
  logic             dmem_stall;
  logic             redirect;
  logic             load_pc;
  logic [NREG-1:0]  load_reg;
  logic [NREG-1:0]  bubble_reg;
  logic             cur_stall;
  logic [2:0]       stall_cause;

  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, ex_valid, ex_mem_read, rd_ex,
           mdu_start, mdu_done, imem_stall, dmem_stall, redirect,
    input  load_pc, load_reg, bubble_reg, cur_stall, stall_cause
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, ex_valid, ex_mem_read, rd_ex,
           mdu_start, mdu_done, imem_stall, dmem_stall, redirect,
    output load_pc, load_reg, bubble_reg, cur_stall, stall_cause
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the in-order rv32i pipeline (IF, ID, EX, MEM x MEM_STAGES, WB).
// Defining HAZ_PERF_CNT_EN adds saturating per-cause performance counters.
module hazard_ctrl #(
  parameter int MEM_STAGES   = 1,
  parameter int LOAD_USE_LAT = 1,
  parameter int REG_W        = 5,
  parameter int PERF_W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_lu_cnt,
  output logic [PERF_W-1:0] perf_mem_cnt,
  output logic [PERF_W-1:0] perf_mdu_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);
  localparam int NREG = 3 + MEM_STAGES;
  localparam int PEND = LOAD_USE_LAT - 1;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_LOAD_USE = 3'd1,
    CAUSE_MEM      = 3'd2,
    CAUSE_MDU      = 3'd3,
    CAUSE_REDIRECT = 3'd4
  } cause_e;

  logic            mdu_busy;
  logic            mem_stall;
  logic            mdu_stall;
  logic            ex_adv;
  logic            ex_load;
  logic            rs1_live;
  logic            rs2_live;
  logic            ex_hit;
  logic            pend_hit;
  logic            lu_hit;
  logic            load_pc;
  logic [NREG-1:0] load_reg;
  logic [NREG-1:0] bubble_reg;
  logic            cur_stall;
  cause_e          cause;

  // Hazard condition decode
  always_comb begin
    mem_stall = hz.imem_stall | hz.dmem_stall;
    mdu_stall = (hz.mdu_start | mdu_busy) & ~hz.mdu_done;
    ex_adv    = ~mem_stall & ~mdu_stall;
    ex_load   = hz.ex_valid & hz.ex_mem_read & (hz.rd_ex != {REG_W{1'b0}});
    rs1_live  = hz.rs1_used_id & (hz.rs1_id != {REG_W{1'b0}});
    rs2_live  = hz.rs2_used_id & (hz.rs2_id != {REG_W{1'b0}});
    ex_hit    = ex_load & ((rs1_live & (hz.rs1_id == hz.rd_ex)) |
                           (rs2_live & (hz.rs2_id == hz.rd_ex)));
    lu_hit    = ex_hit | pend_hit;
  end

  // Loads still in the MEM stages that a dependent op must wait for; idx 0 youngest
  if (PEND > 0) begin : g_pend
    logic [PEND-1:0]  pend_v;
    logic [REG_W-1:0] pend_rd [PEND];

    // Shift pending loads only when EX advances; a frozen EX records nothing
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_v <= {PEND{1'b0}};
        for (int i = 0; i < PEND; i++) pend_rd[i] <= {REG_W{1'b0}};
      end else if (ex_adv) begin
        pend_v[0]  <= ex_load;
        pend_rd[0] <= hz.rd_ex;
        for (int i = 1; i < PEND; i++) begin
          pend_v[i]  <= pend_v[i-1];
          pend_rd[i] <= pend_rd[i-1];
        end
      end else begin
        pend_v <= pend_v;
      end
    end

    // Match ID sources against every valid pending load
    always_comb begin
      pend_hit = 1'b0;
      for (int i = 0; i < PEND; i++) begin
        pend_hit = pend_hit | (pend_v[i] & ((rs1_live & (hz.rs1_id == pend_rd[i])) |
                                            (rs2_live & (hz.rs2_id == pend_rd[i]))));
      end
    end
  end else begin : g_no_pend
    assign pend_hit = 1'b0;
  end

  // MDU busy tracking; keeps updating through memory stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_busy <= 1'b0;
    end else if (hz.mdu_done) begin
      mdu_busy <= 1'b0;
    end else if (hz.mdu_start) begin
      mdu_busy <= 1'b1;
    end else begin
      mdu_busy <= mdu_busy;
    end
  end

  // Priority arbitration: mem > mdu > redirect > load-use
  always_comb begin
    load_pc    = 1'b1;
    load_reg   = {NREG{1'b1}};
    bubble_reg = {NREG{1'b0}};
    cur_stall  = 1'b0;
    cause      = CAUSE_NONE;
    if (mem_stall) begin
      load_pc   = 1'b0;
      load_reg  = {NREG{1'b0}};
      cur_stall = 1'b1;
      cause     = CAUSE_MEM;
    end else if (mdu_stall) begin
      load_pc       = 1'b0;
      load_reg[1:0] = 2'b00;
      bubble_reg[2] = 1'b1;
      cause         = CAUSE_MDU;
    end else if (hz.redirect) begin
      // Wrong-path ID is flushed, so its load-use match is irrelevant
      bubble_reg[1:0] = 2'b11;
      cause           = CAUSE_REDIRECT;
    end else if (lu_hit) begin
      load_pc       = 1'b0;
      load_reg[0]   = 1'b0;
      bubble_reg[1] = 1'b1;
      cause         = CAUSE_LOAD_USE;
    end else begin
      cause = CAUSE_NONE;
    end
  end

  assign hz.load_pc     = load_pc;
  assign hz.load_reg    = load_reg;
  assign hz.bubble_reg  = bubble_reg;
  assign hz.cur_stall   = cur_stall;
  assign hz.stall_cause = cause;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  // Saturating per-cause cycle counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_cnt    <= {PERF_W{1'b0}};
      perf_mem_cnt   <= {PERF_W{1'b0}};
      perf_mdu_cnt   <= {PERF_W{1'b0}};
      perf_flush_cnt <= {PERF_W{1'b0}};
    end else begin
      if (cause == CAUSE_LOAD_USE && perf_lu_cnt != {PERF_W{1'b1}})
        perf_lu_cnt <= perf_lu_cnt + PERF_ONE;
      if (cause == CAUSE_MEM && perf_mem_cnt != {PERF_W{1'b1}})
        perf_mem_cnt <= perf_mem_cnt + PERF_ONE;
      if (cause == CAUSE_MDU && perf_mdu_cnt != {PERF_W{1'b1}})
        perf_mdu_cnt <= perf_mdu_cnt + PERF_ONE;
      if (cause == CAUSE_REDIRECT && perf_flush_cnt != {PERF_W{1'b1}})
        perf_flush_cnt <= perf_flush_cnt + PERF_ONE;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_STAGES=2, LOAD_USE_LAT=2 (one pending entry).
// Output word layout: {load_pc, load_reg[4:0], bubble_reg[4:0], cur_stall, stall_cause[2:0]}.
module tb_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int NREG  = 5;

  localparam logic [14:0] DEF = 15'b1_11111_00000_0_000;
  localparam logic [14:0] LU  = 15'b0_11110_00010_0_001;
  localparam logic [14:0] MEM = 15'b0_00000_00000_1_010;
  localparam logic [14:0] MDU = 15'b0_11100_00100_0_011;
  localparam logic [14:0] RED = 15'b1_11111_00011_0_100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   fails = 0;
  logic [14:0] obs;

  hazard_ctrl_if #(.REG_W(REG_W), .NREG(NREG)) hz ();

`ifdef HAZ_PERF_CNT_EN
  logic [3:0] perf_lu_cnt, perf_mem_cnt, perf_mdu_cnt, perf_flush_cnt;
`endif

  hazard_ctrl #(.MEM_STAGES(2), .LOAD_USE_LAT(2), .REG_W(REG_W), .PERF_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_lu_cnt    (perf_lu_cnt),
    .perf_mem_cnt   (perf_mem_cnt),
    .perf_mdu_cnt   (perf_mdu_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {hz.load_pc, hz.load_reg, hz.bubble_reg, hz.cur_stall, hz.stall_cause};

  task automatic idle();
    hz.rs1_id = 5'd0; hz.rs2_id = 5'd0; hz.rs1_used_id = 1'b0; hz.rs2_used_id = 1'b0;
    hz.ex_valid = 1'b0; hz.ex_mem_read = 1'b0; hz.rd_ex = 5'd0;
    hz.mdu_start = 1'b0; hz.mdu_done = 1'b0;
    hz.imem_stall = 1'b0; hz.dmem_stall = 1'b0; hz.redirect = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_lw(input logic [4:0] rd);
    hz.ex_valid = 1'b1; hz.ex_mem_read = 1'b1; hz.rd_ex = rd;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    if (obs !== DEF) begin $display("FAIL reset_default: got %b want %b", obs, DEF); fails++; end
    vecs++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_use();
    // lw x5 in EX, add x6,x5,x1 in ID
    idle(); ex_lw(5'd5); hz.rs1_id = 5'd5; hz.rs1_used_id = 1'b1; hz.rs2_id = 5'd1; hz.rs2_used_id = 1'b1;
    #2;
    if (obs !== LU) begin $display("FAIL lu_ex_hit: got %b want %b", obs, LU); fails++; end
    vecs++;
    step();
    hz.ex_valid = 1'b0; hz.ex_mem_read = 1'b0; hz.rd_ex = 5'd0;
    #2;
    if (obs !== LU) begin $display("FAIL lu_pending_hit: got %b want %b", obs, LU); fails++; end
    vecs++;
    step();
    #2;
    if (obs !== DEF) begin $display("FAIL lu_released: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
    // unused source never hazards, but the load is still recorded
    idle(); ex_lw(5'd7); hz.rs2_id = 5'd7; hz.rs2_used_id = 1'b0;
    #2;
    if (obs !== DEF) begin $display("FAIL lu_unused_src: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
    hz.ex_valid = 1'b0; hz.ex_mem_read = 1'b0; hz.rd_ex = 5'd0; hz.rs2_used_id = 1'b1;
    #2;
    if (obs !== LU) begin $display("FAIL lu_pending_rs2: got %b want %b", obs, LU); fails++; end
    vecs++;
    step();
    // x0 destination never hazards, in EX or pending
    idle(); ex_lw(5'd0); hz.rs1_used_id = 1'b1;
    #2;
    if (obs !== DEF) begin $display("FAIL lu_x0_ex: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
    hz.ex_valid = 1'b0; hz.ex_mem_read = 1'b0;
    #2;
    if (obs !== DEF) begin $display("FAIL lu_x0_pending: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
  endtask

  task automatic test_mdu();
    idle(); step();
    hz.mdu_start = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #2;
      if (obs !== MDU) begin $display("FAIL mdu_freeze t%0d: got %b want %b", t, obs, MDU); fails++; end
      vecs++;
      step();
      hz.mdu_start = 1'b0;
    end
    hz.mdu_done = 1'b1;
    #2;
    if (obs !== DEF) begin $display("FAIL mdu_done: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
    hz.mdu_done = 1'b0;
    #2;
    if (obs !== DEF) begin $display("FAIL mdu_after_done: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
    // single-cycle op: start and done together
    hz.mdu_start = 1'b1; hz.mdu_done = 1'b1;
    #2;
    if (obs !== DEF) begin $display("FAIL mdu_single_cycle: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
    hz.mdu_start = 1'b0; hz.mdu_done = 1'b0;
    #2;
    if (obs !== DEF) begin $display("FAIL mdu_single_after: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
    // mdu outranks redirect
    hz.mdu_start = 1'b1; hz.redirect = 1'b1;
    #2;
    if (obs !== MDU) begin $display("FAIL mdu_over_redirect: got %b want %b", obs, MDU); fails++; end
    vecs++;
    step();
    idle(); hz.mdu_done = 1'b1; step();
    idle();
  endtask

  task automatic test_mem_during_mdu();
    idle(); hz.mdu_start = 1'b1;
    #2;
    if (obs !== MDU) begin $display("FAIL memmdu_start: got %b want %b", obs, MDU); fails++; end
    vecs++;
    step();
    hz.mdu_start = 1'b0; hz.dmem_stall = 1'b1;
    for (int t = 0; t < 3; t++) begin
      hz.mdu_done = (t == 1) ? 1'b1 : 1'b0;
      #2;
      if (obs !== MEM) begin $display("FAIL memmdu_stall c%0d: got %b want %b", t, obs, MEM); fails++; end
      vecs++;
      step();
    end
    idle();
    #2;
    if (obs !== DEF) begin $display("FAIL memmdu_busy_cleared: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
  endtask

  task automatic test_mem_hold();
    idle(); ex_lw(5'd12);
    #2;
    if (obs !== DEF) begin $display("FAIL hold_record: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
    idle(); hz.imem_stall = 1'b1;
    #2;
    if (obs !== MEM) begin $display("FAIL hold_imem: got %b want %b", obs, MEM); fails++; end
    vecs++;
    step();
    idle(); hz.rs1_id = 5'd12; hz.rs1_used_id = 1'b1;
    #2;
    if (obs !== LU) begin $display("FAIL hold_pending_kept: got %b want %b", obs, LU); fails++; end
    vecs++;
    step();
    idle(); step();
  endtask

  task automatic test_redirect_and_reset();
    idle(); ex_lw(5'd5); hz.rs1_id = 5'd5; hz.rs1_used_id = 1'b1; hz.redirect = 1'b1;
    #2;
    if (obs !== RED) begin $display("FAIL redirect_over_lu: got %b want %b", obs, RED); fails++; end
    vecs++;
    step();
    idle(); step();
    hz.mdu_start = 1'b1;
    #2;
    if (obs !== MDU) begin $display("FAIL rst_mid_mdu_pre: got %b want %b", obs, MDU); fails++; end
    vecs++;
    step();
    hz.mdu_start = 1'b0;
    #2;
    if (obs !== MDU) begin $display("FAIL rst_mid_mdu_busy: got %b want %b", obs, MDU); fails++; end
    vecs++;
    rst = 1'b1;
    #1;
    if (obs !== DEF) begin $display("FAIL rst_async_clear: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
    rst = 1'b0;
    #2;
    if (obs !== DEF) begin $display("FAIL rst_after_release: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
    #2;
    if (obs !== DEF) begin $display("FAIL rst_busy_gone: got %b want %b", obs, DEF); fails++; end
    vecs++;
    step();
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf();
    idle(); rst = 1'b1; step(); rst = 1'b0;
    ex_lw(5'd5); hz.rs1_id = 5'd5; hz.rs1_used_id = 1'b1;
    repeat (5) step();
    if (perf_lu_cnt !== 4'd5) begin $display("FAIL perf_lu_5: got %0d want 5", perf_lu_cnt); fails++; end
    vecs++;
    repeat (15) step();
    if (perf_lu_cnt !== 4'hF) begin $display("FAIL perf_lu_sat: got %h want f", perf_lu_cnt); fails++; end
    vecs++;
    if ({perf_mem_cnt, perf_mdu_cnt, perf_flush_cnt} !== 12'h000) begin
      $display("FAIL perf_others: got %h %h %h want 0 0 0", perf_mem_cnt, perf_mdu_cnt, perf_flush_cnt);
      fails++;
    end
    vecs++;
    idle();
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_mdu();
    test_mem_during_mdu();
    test_mem_hold();
    test_redirect_and_reset();
`ifdef HAZ_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
